dmem_initiator: RTL

Requester-side controller for the 32×16 data memory. It accepts load, store, block-copy and block-fill commands from the core over a valid/ready handshake. It sequences the memory's `address`/`in`/`read` pins one word at a time and returns a single response per command. The data memory writes combinationally whenever `read` is low, so this block is the only place that drives that pin, and it drives it glitch-free from registers.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_initiator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the 32x16 data memory and its requester-side controller.
// Holds geometry constants, the command opcode encoding and the controller FSM states.
package dmem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_COPY  = 2'b10,
    OP_FILL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } st_e;

endpackage

// File: rtl/dmem_initiator.sv
// Sequences LOAD/STORE/COPY/FILL onto the data memory one word per cycle; response lands k+2 (LOAD/STORE), k+N+1 (FILL), k+2N+1 (COPY), k+1 (error).
// req_ready is high only in IDLE, so a busy block simply ignores req_valid; all memory pins are driven from registers.
module dmem_initiator #(
  parameter int DATA_W = dmem_pkg::DATA_W,
  parameter int ADDR_W = dmem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [ADDR_W:0]   req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);
  import dmem_pkg::*;

  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  st_e               r_state, w_state_nxt;
  op_e               r_op, w_op_nxt;
  logic [ADDR_W-1:0] r_src, w_src_nxt;
  logic [ADDR_W-1:0] r_dst, w_dst_nxt;
  logic [ADDR_W:0]   r_left, w_left_nxt;
  logic [ADDR_W:0]   r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_mem_read, w_mem_read_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;

  op_e               w_req_op;
  logic              w_len_bad;
  logic [ADDR_W:0]   w_cnt_inc;

  assign w_req_op  = op_e'(req_op);
  assign w_len_bad = (req_len == '0) || (req_len > LEN_MAX);
  assign w_cnt_inc = r_cnt + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_LOAD;
      r_src       <= '0;
      r_dst       <= '0;
      r_left      <= '0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_src       <= w_src_nxt;
      r_dst       <= w_dst_nxt;
      r_left      <= w_left_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  // r_src/r_dst always point at the next word to read/write; r_mem_wdata doubles as the COPY holding register.
  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_src_nxt       = r_src;
    w_dst_nxt       = r_dst;
    w_left_nxt      = r_left;
    w_cnt_nxt       = r_cnt;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_read_nxt  = 1'b1;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;

    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_op_nxt   = w_req_op;
          w_cnt_nxt  = '0;
          w_src_nxt  = req_addr + ADDR_ONE;
          w_dst_nxt  = req_addr + ADDR_ONE;
          w_left_nxt = ((w_req_op == OP_LOAD) || (w_req_op == OP_STORE)) ? CNT_ONE : req_len;
          unique case (w_req_op)
            OP_LOAD: begin
              w_state_nxt    = ST_RD;
              w_mem_addr_nxt = req_addr;
            end
            OP_STORE: begin
              w_state_nxt     = ST_WR;
              w_mem_addr_nxt  = req_addr;
              w_mem_wdata_nxt = req_wdata;
              w_mem_read_nxt  = 1'b0;
            end
            OP_FILL, OP_COPY: begin
              if (w_len_bad) begin
                w_state_nxt     = ST_DONE;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_data_nxt  = '0;
                w_rsp_err_nxt   = 1'b1;
              end else if (w_req_op == OP_FILL) begin
                w_state_nxt     = ST_WR;
                w_mem_addr_nxt  = req_addr;
                w_mem_wdata_nxt = req_wdata;
                w_mem_read_nxt  = 1'b0;
              end else begin
                w_state_nxt    = ST_RD;
                w_mem_addr_nxt = req_addr;
                w_dst_nxt      = req_dst;
              end
            end
          endcase
        end
      end

      ST_RD: begin
        if (r_op == OP_LOAD) begin
          w_state_nxt     = ST_DONE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = mem_rdata;
          w_rsp_err_nxt   = 1'b0;
        end else begin
          w_state_nxt     = ST_WR;
          w_mem_addr_nxt  = r_dst;
          w_mem_wdata_nxt = mem_rdata;
          w_mem_read_nxt  = 1'b0;
          w_dst_nxt       = r_dst + ADDR_ONE;
        end
      end

      ST_WR: begin
        w_cnt_nxt  = w_cnt_inc;
        w_left_nxt = r_left - CNT_ONE;
        if (r_left == CNT_ONE) begin
          w_state_nxt     = ST_DONE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = (r_op == OP_STORE) ? '0 : DATA_W'(w_cnt_inc);
          w_rsp_err_nxt   = 1'b0;
        end else if (r_op == OP_FILL) begin
          w_mem_addr_nxt = r_dst;
          w_mem_read_nxt = 1'b0;
          w_dst_nxt      = r_dst + ADDR_ONE;
        end else begin
          w_state_nxt    = ST_RD;
          w_mem_addr_nxt = r_src;
          w_src_nxt      = r_src + ADDR_ONE;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_read  = r_mem_read;

endmodule
